prt_vtb_cg_ctl: RTL and testbench
=================================

Name: prt_vtb_cg_ctl

Overview:
Controller/sequencer for the video toolbox clock generator.
- Accepts a 32-bit reference-clock value and a 32-bit video-clock value from the host/CPU side over a req/ack handshake.
- Restarts the generator: run low, then run high, then four VPS word writes.
- Monitors the resulting clock-enable rate over a fixed window and reports lock status.
- Sits between the toolbox register interface and the generator's CTL_RUN/VPS/CKE ports.

Parameters:
P_STOP_CYC, 4, cycles CG_RUN_OUT is held low on restart (min 2).
P_MON_WIN, 1024, monitor window length in clocks (min 2).
P_MON_W, 16, width of monitor count.

Ports:
CLK_IN  in  1  clock.
RST_IN  in  1  reset, synchronous, active-low.
CFG_REFCLK_IN  in  32  reference clock increment.
CFG_VIDCLK_IN  in  32  video clock increment.
CFG_REQ_IN  in  1  configuration request (level).
CFG_STOP_IN  in  1  stop generator.
CFG_ACK_OUT  out  1  one-cycle acknowledge.
CFG_ERR_OUT  out  1  error qualifier, valid with ACK.
CG_RUN_OUT  out  1  generator run.
CG_VPS_IDX_OUT  out  4  VPS index.
CG_VPS_DAT_OUT  out  16  VPS data.
CG_VPS_VLD_OUT  out  1  VPS valid.
CG_CKE_IN  in  1  generator clock enable (monitored).
STA_LOCK_OUT  out  1  generator running and first window complete.
STA_CNT_OUT  out  P_MON_W  CKE-high count of last window.
STA_CNT_VLD_OUT  out  1  one-cycle pulse per window.

Behaviour:
- Reset (RST_IN=0 at edge): state IDLE. All outputs 0, including CG_RUN_OUT, ACK, ERR, VLD, LOCK, CNT. Latched config cleared. Reset mid-sequence aborts it with no ACK.
- States: IDLE, STOP, START, WR, RUN.
- REQ is sampled only in IDLE and RUN, and is ignored in the cycle ACK is high. Requester drops REQ the cycle after ACK.
- Validation at sample: reject if REFCLK==0 or VIDCLK>REFCLK. On reject: next cycle ACK=1, ERR=1, state unchanged, generator untouched.
- Valid REQ: latch both values, go to STOP.
- STOP: CG_RUN_OUT=0 for P_STOP_CYC cycles, then START.
- START: CG_RUN_OUT=1 for 2 cycles, which covers the generator's one-cycle run register; then WR.
- WR: four consecutive cycles with VLD=1 and RUN=1.
  - IDX 0 = REFCLK[31:16], then IDX 1 = REFCLK[15:0].
  - IDX 2 = VIDCLK[31:16], then IDX 3 = VIDCLK[15:0].
  - Then RUN with ACK=1, ERR=0.
- Latency: ACK is high in the cycle following edge N = P_STOP_CYC+6 after the sampling edge (N=10 by default).
- Outside WR: VLD=0, IDX=0, DAT=0.
- RUN: CG_RUN_OUT=1. A new valid REQ restarts via STOP; LOCK drops immediately.
- CFG_STOP_IN has priority over REQ in all states. Sequence: STOP for P_STOP_CYC cycles, then IDLE with RUN=0. If the stop aborts an un-acked request, ACK=1 and ERR=1 on the STOP entry cycle.
- CFG_STOP_IN in IDLE: no effect, no ACK.
- Monitor (RUN only):
  - Window counter counts 0..P_MON_W IN-1 clocks; a CKE counter increments on each CG_CKE_IN=1 and saturates at all-ones.
  - At window end: STA_CNT_OUT is loaded with the count including the final cycle, STA_CNT_VLD_OUT pulses, both counters reset, LOCK is set.
  - Leaving RUN: counters clear, LOCK=0, STA_CNT_OUT holds its last value.
- Simultaneous window end and restart: restart wins, no VLD pulse.

Test Plan:
1. Reset then REQ with REFCLK=0x00010000, VIDCLK=0x00008000 -> RUN 0 until ACK. Writes appear in order (0,0x0001),(1,0x0000),(2,0x0000),(3,0x8000). ACK at edge 10, ERR=0. After one window, STA_CNT_OUT=512±2, LOCK=1.
2. REQ with REFCLK=0 or VIDCLK=0x20000 > REFCLK=0x10000 -> ACK=1/ERR=1 next cycle, no VLD, RUN unchanged.
3. In RUN, new REQ with VIDCLK=0x4000 -> RUN low for 4 cycles, LOCK drops, rewrite, next count 256±2.
4. CFG_STOP_IN asserted during WR (after IDX 1) -> ACK/ERR=1, no further writes, RUN low, IDLE, LOCK=0.
5. CG_CKE_IN tied 1 with P_MON_W=8, P_MON_WIN=1024 -> STA_CNT_OUT=0xFF (saturated).
6. RST_IN low mid-STOP and mid-RUN -> all outputs 0 next cycle, no ACK; a subsequent REQ completes normally.

Source files
------------

// File: rtl/prt_vtb_cg_ctl_if.sv
// Host-side configuration bus of the clock generator controller.
// Carries the reference/video increments, the request/stop levels and the ack/err reply.
interface prt_vtb_cg_ctl_if;
    logic [31:0] CFG_REFCLK_IN;
    logic [31:0] CFG_VIDCLK_IN;
    logic        CFG_REQ_IN;
    logic        CFG_STOP_IN;
    logic        CFG_ACK_OUT;
    logic        CFG_ERR_OUT;

    modport master (
        output CFG_REFCLK_IN,
        output CFG_VIDCLK_IN,
        output CFG_REQ_IN,
        output CFG_STOP_IN,
        input  CFG_ACK_OUT,
        input  CFG_ERR_OUT
    );

    modport slave (
        input  CFG_REFCLK_IN,
        input  CFG_VIDCLK_IN,
        input  CFG_REQ_IN,
        input  CFG_STOP_IN,
        output CFG_ACK_OUT,
        output CFG_ERR_OUT
    );
endinterface

// File: rtl/prt_vtb_cg_ctl.sv
// Video toolbox clock generator sequencer: restart, VPS word load and CKE rate monitor.
// Every output is registered; a single FSM process owns all state.
module prt_vtb_cg_ctl #(
    parameter int P_STOP_CYC = 4,
    parameter int P_MON_WIN  = 1024,
    parameter int P_MON_W    = 16
) (
    input  logic               CLK_IN,
    input  logic               RST_IN,
    prt_vtb_cg_ctl_if.slave    cfg,
    output logic               CG_RUN_OUT,
    output logic [3:0]         CG_VPS_IDX_OUT,
    output logic [15:0]        CG_VPS_DAT_OUT,
    output logic               CG_VPS_VLD_OUT,
    input  logic               CG_CKE_IN,
    output logic               STA_LOCK_OUT,
    output logic [P_MON_W-1:0] STA_CNT_OUT,
    output logic               STA_CNT_VLD_OUT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STOP,
        S_START,
        S_WR,
        S_RUN
    } state_t;

    localparam int CW = $clog2(P_STOP_CYC + 4);
    localparam int WW = $clog2(P_MON_WIN);
    localparam logic [CW-1:0] STOP_LAST = CW'(P_STOP_CYC - 1);
    localparam logic [CW-1:0] START_LAST = CW'(1);
    localparam logic [WW-1:0] WIN_LAST = WW'(P_MON_WIN - 1);

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               stopping_q;
    logic [31:0]        ref_q;
    logic [31:0]        vid_q;
    logic               ack_q;
    logic               err_q;
    logic               run_q;
    logic               vld_q;
    logic [3:0]         idx_q;
    logic [15:0]        dat_q;
    logic               lock_q;
    logic               sta_vld_q;
    logic [P_MON_W-1:0] sta_cnt_q;
    logic [WW-1:0]      win_q;
    logic [P_MON_W-1:0] cke_q;

    logic               req_s;
    logic               cfg_ok;
    logic               stop_s;
    logic               mon_en;
    logic [1:0]         wr_nxt;
    logic [P_MON_W-1:0] cke_d;

    function automatic logic [15:0] vps_word(
        input logic [1:0]  i,
        input logic [31:0] r,
        input logic [31:0] v
    );
        logic [15:0] w;
        unique case (i)
            2'd0:    w = r[31:16];
            2'd1:    w = r[15:0];
            2'd2:    w = v[31:16];
            default: w = v[15:0];
        endcase
        return w;
    endfunction

    // REQ is a level held through the ack cycle, so that cycle is masked
    assign req_s  = cfg.CFG_REQ_IN && !ack_q;
    assign cfg_ok = (cfg.CFG_REFCLK_IN != 32'd0) &&
                    (cfg.CFG_VIDCLK_IN <= cfg.CFG_REFCLK_IN);
    assign stop_s = cfg.CFG_STOP_IN && (state_q != S_IDLE) && !stopping_q;
    assign mon_en = (state_q == S_RUN) && !stop_s && !(req_s && cfg_ok);
    assign wr_nxt = cnt_q[1:0] + 2'd1;
    assign cke_d  = (CG_CKE_IN && (cke_q != '1)) ? cke_q + 1'b1 : cke_q;

    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            stopping_q <= 1'b0;
            ref_q      <= '0;
            vid_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            run_q      <= 1'b0;
            vld_q      <= 1'b0;
            idx_q      <= '0;
            dat_q      <= '0;
            lock_q     <= 1'b0;
            sta_vld_q  <= 1'b0;
            sta_cnt_q  <= '0;
            win_q      <= '0;
            cke_q      <= '0;
        end else begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            vld_q     <= 1'b0;
            idx_q     <= '0;
            dat_q     <= '0;
            sta_vld_q <= 1'b0;

            if (stop_s) begin
                state_q    <= S_STOP;
                stopping_q <= 1'b1;
                cnt_q      <= '0;
                run_q      <= 1'b0;
                // Anything short of RUN still owes the host an answer
                if (state_q != S_RUN) begin
                    ack_q <= 1'b1;
                    err_q <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    S_IDLE, S_RUN: begin
                        if (req_s) begin
                            if (cfg_ok) begin
                                ref_q   <= cfg.CFG_REFCLK_IN;
                                vid_q   <= cfg.CFG_VIDCLK_IN;
                                state_q <= S_STOP;
                                cnt_q   <= '0;
                                run_q   <= 1'b0;
                            end else begin
                                ack_q <= 1'b1;
                                err_q <= 1'b1;
                            end
                        end
                    end
                    S_STOP: begin
                        if (cnt_q == STOP_LAST) begin
                            cnt_q <= '0;
                            if (stopping_q) begin
                                state_q    <= S_IDLE;
                                stopping_q <= 1'b0;
                            end else begin
                                state_q <= S_START;
                                run_q   <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_START: begin
                        if (cnt_q == START_LAST) begin
                            state_q <= S_WR;
                            cnt_q   <= '0;
                            vld_q   <= 1'b1;
                            dat_q   <= vps_word(2'd0, ref_q, vid_q);
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_WR: begin
                        if (cnt_q[1:0] == 2'd3) begin
                            state_q <= S_RUN;
                            cnt_q   <= '0;
                            ack_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            vld_q <= 1'b1;
                            idx_q <= {2'b00, wr_nxt};
                            dat_q <= vps_word(wr_nxt, ref_q, vid_q);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end

            // Window end loses to a restart or stop because mon_en is low then
            if (mon_en) begin
                if (win_q == WIN_LAST) begin
                    win_q     <= '0;
                    cke_q     <= '0;
                    sta_cnt_q <= cke_d;
                    sta_vld_q <= 1'b1;
                    lock_q    <= 1'b1;
                end else begin
                    win_q <= win_q + 1'b1;
                    cke_q <= cke_d;
                end
            end else begin
                win_q  <= '0;
                cke_q  <= '0;
                lock_q <= 1'b0;
            end
        end
    end

    assign cfg.CFG_ACK_OUT = ack_q;
    assign cfg.CFG_ERR_OUT = err_q;
    assign CG_RUN_OUT      = run_q;
    assign CG_VPS_IDX_OUT  = idx_q;
    assign CG_VPS_DAT_OUT  = dat_q;
    assign CG_VPS_VLD_OUT  = vld_q;
    assign STA_LOCK_OUT    = lock_q;
    assign STA_CNT_OUT     = sta_cnt_q;
    assign STA_CNT_VLD_OUT = sta_vld_q;

endmodule

// File: tb/tb_prt_vtb_cg_ctl.sv
// Directed bench for prt_vtb_cg_ctl with a phase-accumulator CKE source.
// A second 8-bit-monitor instance sees CKE tied high to exercise saturation.
module tb_prt_vtb_cg_ctl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    prt_vtb_cg_ctl_if cfg_if ();
    prt_vtb_cg_ctl_if sat_if ();

    logic        run;
    logic [3:0]  idx;
    logic [15:0] dat;
    logic        vld;
    logic        cke;
    logic        lock;
    logic [15:0] sta_cnt;
    logic        sta_vld;

    logic        s_run;
    logic [3:0]  s_idx;
    logic [15:0] s_dat;
    logic        s_vld;
    logic        s_lock;
    logic [7:0]  s_cnt;
    logic        s_cvld;

    prt_vtb_cg_ctl u_dut (
        .CLK_IN          (clk),
        .RST_IN          (rst_n),
        .cfg             (cfg_if.slave),
        .CG_RUN_OUT      (run),
        .CG_VPS_IDX_OUT  (idx),
        .CG_VPS_DAT_OUT  (dat),
        .CG_VPS_VLD_OUT  (vld),
        .CG_CKE_IN       (cke),
        .STA_LOCK_OUT    (lock),
        .STA_CNT_OUT     (sta_cnt),
        .STA_CNT_VLD_OUT (sta_vld)
    );

    prt_vtb_cg_ctl #(.P_MON_W(8), .P_MON_WIN(1024)) u_sat (
        .CLK_IN          (clk),
        .RST_IN          (rst_n),
        .cfg             (sat_if.slave),
        .CG_RUN_OUT      (s_run),
        .CG_VPS_IDX_OUT  (s_idx),
        .CG_VPS_DAT_OUT  (s_dat),
        .CG_VPS_VLD_OUT  (s_vld),
        .CG_CKE_IN       (1'b1),
        .STA_LOCK_OUT    (s_lock),
        .STA_CNT_OUT     (s_cnt),
        .STA_CNT_VLD_OUT (s_cvld)
    );

    // Generator stand-in: CKE rate = vid/ref while run is high
    logic [31:0] g_ref = 32'd1;
    logic [31:0] g_vid = 32'd0;
    logic [32:0] acc = '0;
    always @(posedge clk) begin
        if (!run) begin
            acc <= '0;
            cke <= 1'b0;
        end else if (acc + {1'b0, g_vid} >= {1'b0, g_ref}) begin
            acc <= acc + {1'b0, g_vid} - {1'b0, g_ref};
            cke <= 1'b1;
        end else begin
            acc <= acc + {1'b0, g_vid};
            cke <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cfg(input string tag, input logic [31:0] r,
                          input logic [31:0] v);
        logic [15:0] w [4];
        w[0] = r[31:16];
        w[1] = r[15:0];
        w[2] = v[31:16];
        w[3] = v[15:0];
        cfg_if.CFG_REFCLK_IN = r;
        cfg_if.CFG_VIDCLK_IN = v;
        cfg_if.CFG_REQ_IN = 1'b1;
        g_ref = r;
        g_vid = v;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            chk({tag, "_run"}, 32'(run), 32'(k >= 4));
            chk({tag, "_ack"}, 32'(cfg_if.CFG_ACK_OUT), 32'(k == 10));
            chk({tag, "_vld"}, 32'(vld), 32'(k >= 6 && k <= 9));
            if (k >= 6 && k <= 9) begin
                chk({tag, "_idx"}, 32'(idx), 32'(k - 6));
                chk({tag, "_dat"}, 32'(dat), 32'(w[k-6]));
            end else begin
                chk({tag, "_idx0"}, 32'({idx, dat}), 32'd0);
            end
            if (k == 0 || k == 10)
                chk({tag, "_lock0"}, 32'(lock), 32'd0);
            if (k == 10) begin
                chk({tag, "_err"}, 32'(cfg_if.CFG_ERR_OUT), 32'd0);
                cfg_if.CFG_REQ_IN = 1'b0;
            end
        end
    endtask

    task automatic wait_win(input string tag, input int lo, input int hi);
        int n = 0;
        while (!sta_vld && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 1200), 32'd1);
        chk({tag, "_cnt"}, 32'(int'(sta_cnt) >= lo && int'(sta_cnt) <= hi), 32'd1);
        chk({tag, "_lock"}, 32'(lock), 32'd1);
    endtask

    initial begin
        cfg_if.CFG_REFCLK_IN = '0;
        cfg_if.CFG_VIDCLK_IN = '0;
        cfg_if.CFG_REQ_IN = 1'b0;
        cfg_if.CFG_STOP_IN = 1'b0;
        sat_if.CFG_REFCLK_IN = '0;
        sat_if.CFG_VIDCLK_IN = '0;
        sat_if.CFG_REQ_IN = 1'b0;
        sat_if.CFG_STOP_IN = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_ackerr", 32'({cfg_if.CFG_ACK_OUT, cfg_if.CFG_ERR_OUT}), 32'd0);
        chk("rst_vps", 32'({vld, idx, dat}), 32'd0);
        chk("rst_sta", 32'({lock, sta_vld, sta_cnt}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: first config, rate 1/2; saturating instance alongside
        sat_if.CFG_REFCLK_IN = 32'h0001_0000;
        sat_if.CFG_VIDCLK_IN = 32'h0000_8000;
        sat_if.CFG_REQ_IN = 1'b1;
        do_cfg("t1", 32'h0001_0000, 32'h0000_8000);
        chk("t1_sat_ack", 32'(sat_if.CFG_ACK_OUT), 32'd1);
        sat_if.CFG_REQ_IN = 1'b0;
        wait_win("t1_win", 510, 514);
        chk("t5_sat_vld", 32'(s_cvld), 32'd1);
        chk("t5_sat_cnt", 32'(s_cnt), 32'hFF);
        chk("t5_sat_lock", 32'({s_run, s_lock}), 32'd3);

        // Test 2: rejects while running
        cfg_if.CFG_REFCLK_IN = 32'd0;
        cfg_if.CFG_VIDCLK_IN = 32'd0;
        cfg_if.CFG_REQ_IN = 1'b1;
        @(negedge clk);
        chk("t2a_ackerr", 32'({cfg_if.CFG_ACK_OUT, cfg_if.CFG_ERR_OUT}), 32'd3);
        chk("t2a_run_vld", 32'({run, vld}), 32'd2);
        cfg_if.CFG_REQ_IN = 1'b0;
        @(negedge clk);
        chk("t2a_ack_once", 32'(cfg_if.CFG_ACK_OUT), 32'd0);
        cfg_if.CFG_REFCLK_IN = 32'h0001_0000;
        cfg_if.CFG_VIDCLK_IN = 32'h0002_0000;
        cfg_if.CFG_REQ_IN = 1'b1;
        @(negedge clk);
        chk("t2b_ackerr", 32'({cfg_if.CFG_ACK_OUT, cfg_if.CFG_ERR_OUT}), 32'd3);
        chk("t2b_run_vld", 32'({run, vld}), 32'd2);
        cfg_if.CFG_REQ_IN = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t2b_hold", 32'({run, vld, cfg_if.CFG_ACK_OUT}), 32'd4);
        end

        // Test 3: restart from RUN at rate 1/4
        do_cfg("t3", 32'h0001_0000, 32'h0000_4000);
        wait_win("t3_win", 254, 258);

        // Reset mid-RUN clears everything, including the held count
        rst_n = 1'b0;
        @(negedge clk);
        chk("rrun_out", 32'({run, vld, lock, sta_vld, cfg_if.CFG_ACK_OUT}), 32'd0);
        chk("rrun_cnt", 32'(sta_cnt), 32'd0);
        rst_n = 1'b1;

        // Test 4: stop during the VPS writes, after index 1
        cfg_if.CFG_REFCLK_IN = 32'h0001_0000;
        cfg_if.CFG_VIDCLK_IN = 32'h0000_8000;
        cfg_if.CFG_REQ_IN = 1'b1;
        repeat (8) @(negedge clk);
        chk("t4_idx1", 32'({vld, idx}), 32'h11);
        cfg_if.CFG_STOP_IN = 1'b1;
        @(negedge clk);
        chk("t4_ackerr", 32'({cfg_if.CFG_ACK_OUT, cfg_if.CFG_ERR_OUT}), 32'd3);
        chk("t4_out", 32'({run, vld, lock}), 32'd0);
        cfg_if.CFG_STOP_IN = 1'b0;
        cfg_if.CFG_REQ_IN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t4_quiet", 32'({run, vld, lock, cfg_if.CFG_ACK_OUT}), 32'd0);
        end
        cfg_if.CFG_STOP_IN = 1'b1;
        @(negedge clk);
        chk("t4_idle_stop", 32'({run, cfg_if.CFG_ACK_OUT}), 32'd0);
        cfg_if.CFG_STOP_IN = 1'b0;

        // Test 6: reset mid-STOP, then a clean configuration
        cfg_if.CFG_REQ_IN = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        cfg_if.CFG_REQ_IN = 1'b0;
        @(negedge clk);
        chk("rstop_out", 32'({run, vld, lock, cfg_if.CFG_ACK_OUT, cfg_if.CFG_ERR_OUT}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstop_noack", 32'(cfg_if.CFG_ACK_OUT), 32'd0);
        do_cfg("t6", 32'h1234_5678, 32'h0123_4567);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
